wb_lane_buffer: RTL and testbench
=================================

# wb_lane_buffer

Multi-lane write-back stage that takes up to LANES results per cycle from the EX/WB pipeline register and queues them in a DEPTH-entry in-order buffer. It retires one entry per cycle to both the register-file write port and the external result port. Retirement uses a valid/ready handshake on the result port. The block raises a stall toward the pipeline when the buffer cannot absorb a full lane group, and gives bypass lookup into pending writes. It replaces the single-lane, pass-through write-back stage.

## Interface
Parameters:
- DATA_W, 16: result data width
- ADDR_W, 3: register address width
- LANES, 2: results offered per cycle; 1..4
- DEPTH, 4: buffer entries; DEPTH >= LANES

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- internal_reset  in  1  synchronous flush: empties buffer, suppresses all writes and output in the same cycle
- ex_valid  in  LANES  per-lane result present
- ex_wr_en  in  LANES  per-lane register-write request
- ex_dst  in  LANES*ADDR_W  per-lane destination register
- ex_data  in  LANES*DATA_W  per-lane result
- wb_stall  out  1  buffer cannot accept a full group; EX holds its inputs
- out_valid  out  1  head entry presented
- out_ready  in  1  consumer accepts head
- out_data  out  DATA_W  head result
- out_dst  out  ADDR_W  head destination
- rf_we  out  1  register-file write strobe
- rf_addr  out  ADDR_W  register-file write address (= out_dst)
- rf_data  out  DATA_W  register-file write data (= out_data)
- byp_addr  in  ADDR_W  bypass lookup address
- byp_hit  out  1  a pending buffered entry with wr_en targets byp_addr
- byp_data  out  DATA_W  data of the youngest such entry; 0 when no hit

## Operation
- Buffer is a circular queue: head pointer, tail pointer, count of width $clog2(DEPTH+1). Pointers wrap modulo DEPTH; non-power-of-two DEPTH is supported by explicit wrap.
- free = DEPTH - count, taken from registered count only. wb_stall = (free < LANES). A same-cycle pop is not credited.
- Accept: ex_fire = |ex_valid & !wb_stall & !internal_reset. On fire, valid lanes are pushed in ascending lane order into consecutive slots. Invalid lanes are skipped and leave no holes. Lanes with ex_valid=1 and ex_wr_en=0 are still queued and output, with rf_we=0.
- Retire: out_valid = (count != 0) & !internal_reset. pop = out_valid & out_ready. rf_we = pop & head.wr_en.
- Push and pop in the same cycle are allowed: count_next = count + pushed - pop.
- Bypass: scan from tail-1 back to head. Report the youngest entry with wr_en & dst==byp_addr. Same-cycle incoming ex lanes are not searched.
- internal_reset=1: count, head and tail go to 0 at the next edge. out_valid, rf_we and byp_hit are forced to 0 combinationally. No push occurs that cycle.
- rst_n low: asynchronous clear of pointers, count and all entry valid bits. Entry data is not reset.

## Timing
- Reset values: out_valid=0, rf_we=0, wb_stall=0 (for LANES<=DEPTH), byp_hit=0, out_data/out_dst/byp_data=0 while nothing is valid.
- Latency: a result pushed at edge N is at the head and visible on out_valid after edge N if the buffer was empty. Accept-to-retire is 1 cycle minimum.
- Throughput: 1 retire per cycle. Sustained LANES>1 input saturates the buffer and stalls by design.
- out_* must hold stable while out_valid & !out_ready.
- wb_stall depends only on registered state, so there is no combinational path from out_ready to wb_stall.
- Buffer full (count=DEPTH): wb_stall=1. Buffer empty: out_valid=0 and byp_hit=0.

## Structure
- Shared package wb_pkg holds:
  - wb_entry_t struct {wr_en, dst, data}
  - default parameter constants
  - ptr_inc() wrap function
- One sub-module, wb_result_fifo, is natural. It holds storage, pointers, count, a multi-push compaction port, a single-pop port and the bypass scan. The top level adds stall, handshake gating and internal_reset masking.

## Test plan
- Reset, then a single lane {dst=3, data=0x1234, wr_en=1} with out_ready=1 -> next cycle out_valid=1 and rf_we=1 with addr 3 and data 0x1234; the cycle after, out_valid=0.
- LANES=2, DEPTH=4, out_ready=0, four groups of both lanes valid -> wb_stall=1 after 2 groups; exactly 4 entries are held, in order lane0, lane1, lane0, lane1.
- ex_valid=2'b10 {dst=5, wr_en=0} -> one entry queued; it is output with rf_we=0 and byp_hit=0 for addr 5.
- Queue dst=2 twice with data 0xAAAA then 0xBBBB, byp_addr=2 -> byp_hit=1 and byp_data=0xBBBB; after the first pop, data is still 0xBBBB.
- Full buffer, then internal_reset for 1 cycle -> out_valid and rf_we are 0 that cycle; next cycle count=0 and wb_stall=0.
- Push and pop in the same cycle at count=DEPTH-1 with the pointer at the wrap boundary -> count is unchanged and order is preserved across the wrap.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types, default configuration and pointer helper for the lane write-back buffer.
package wb_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;
    localparam int LANES_DEF  = 2;
    localparam int DEPTH_DEF  = 4;

    // Buffer entry in the default configuration; modules re-derive it for their own widths.
    typedef struct packed {
        logic                  wr_en;
        logic [ADDR_W_DEF-1:0] dst;
        logic [DATA_W_DEF-1:0] data;
    } wb_entry_t;

    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        int unsigned nxt;
        if (ptr + 32'd1 >= depth) begin
            nxt = 32'd0;
        end else begin
            nxt = ptr + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/wb_lane_buffer_if.sv
// Bus bundle between the EX/WB pipeline, register file, result consumer and bypass network.
interface wb_lane_buffer_if
    import wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LANES  = LANES_DEF
) ();

    logic [LANES-1:0]        ex_valid;
    logic [LANES-1:0]        ex_wr_en;
    logic [LANES*ADDR_W-1:0] ex_dst;
    logic [LANES*DATA_W-1:0] ex_data;
    logic                    wb_stall;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       out_data;
    logic [ADDR_W-1:0]       out_dst;
    logic                    rf_we;
    logic [ADDR_W-1:0]       rf_addr;
    logic [DATA_W-1:0]       rf_data;
    logic [ADDR_W-1:0]       byp_addr;
    logic                    byp_hit;
    logic [DATA_W-1:0]       byp_data;

    modport master (
        output ex_valid, ex_wr_en, ex_dst, ex_data, out_ready, byp_addr,
        input  wb_stall, out_valid, out_data, out_dst, rf_we, rf_addr, rf_data,
               byp_hit, byp_data
    );

    modport slave (
        input  ex_valid, ex_wr_en, ex_dst, ex_data, out_ready, byp_addr,
        output wb_stall, out_valid, out_data, out_dst, rf_we, rf_addr, rf_data,
               byp_hit, byp_data
    );

endinterface

// File: rtl/wb_result_fifo.sv
// In-order circular result store: compacting multi-lane push, single pop, youngest-match bypass scan.
module wb_result_fifo
    import wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush_i,
    input  logic                    push_en_i,
    input  logic [LANES-1:0]        push_valid_i,
    input  logic [LANES-1:0]        push_wr_en_i,
    input  logic [LANES*ADDR_W-1:0] push_dst_i,
    input  logic [LANES*DATA_W-1:0] push_data_i,
    input  logic                    pop_i,
    output logic [CNT_W-1:0]        count_o,
    output logic                    head_wr_en_o,
    output logic [ADDR_W-1:0]       head_dst_o,
    output logic [DATA_W-1:0]       head_data_o,
    input  logic [ADDR_W-1:0]       byp_addr_i,
    output logic                    byp_hit_o,
    output logic [DATA_W-1:0]       byp_data_o
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PUSH_W = $clog2(LANES + 1);

    typedef struct packed {
        logic              wr_en;
        logic [ADDR_W-1:0] dst;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    entry_t            lane_entry [LANES];
    logic [PTR_W-1:0]  lane_slot [LANES];
    logic [LANES-1:0]  lane_we;
    logic [PTR_W-1:0]  walk_ptr;
    logic [PUSH_W-1:0] pushed;
    logic [PTR_W-1:0]  scan_ptr;

    // Valid lanes take consecutive slots from the tail so skipped lanes leave no holes.
    always_comb begin
        walk_ptr = tail_q;
        pushed   = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_entry[l].wr_en = push_wr_en_i[l];
            lane_entry[l].dst   = push_dst_i[l*ADDR_W +: ADDR_W];
            lane_entry[l].data  = push_data_i[l*DATA_W +: DATA_W];
            lane_slot[l]        = walk_ptr;
            lane_we[l]          = push_en_i & push_valid_i[l];
            if (lane_we[l]) begin
                walk_ptr = PTR_W'(ptr_inc(32'(walk_ptr), DEPTH));
                pushed   = pushed + PUSH_W'(1);
            end else begin
                walk_ptr = walk_ptr;
            end
        end
    end

    // Pointer, count and occupancy next state; flush overrides everything.
    always_comb begin
        head_d  = head_q;
        tail_d  = walk_ptr;
        vld_d   = vld_q;
        count_d = count_q + CNT_W'(pushed) - CNT_W'(pop_i);
        if (pop_i) begin
            head_d         = PTR_W'(ptr_inc(32'(head_q), DEPTH));
            vld_d[head_q]  = 1'b0;
        end else begin
            head_d = head_q;
        end
        for (int l = 0; l < LANES; l++) begin
            if (lane_we[l]) begin
                vld_d[lane_slot[l]] = 1'b1;
            end else begin
                vld_d = vld_d;
            end
        end
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            vld_d   = '0;
        end else begin
            count_d = count_d;
        end
    end

    // Control state with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            vld_q   <= vld_d;
        end
    end

    // Entry payload storage, intentionally without reset.
    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (lane_we[l]) begin
                mem_q[lane_slot[l]] <= lane_entry[l];
            end
        end
    end

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        byp_hit_o  = 1'b0;
        byp_data_o = '0;
        scan_ptr   = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[scan_ptr] && mem_q[scan_ptr].wr_en && (mem_q[scan_ptr].dst == byp_addr_i)) begin
                byp_hit_o  = 1'b1;
                byp_data_o = mem_q[scan_ptr].data;
            end else begin
                byp_hit_o = byp_hit_o;
            end
            scan_ptr = PTR_W'(ptr_inc(32'(scan_ptr), DEPTH));
        end
    end

    assign count_o      = count_q;
    assign head_wr_en_o = mem_q[head_q].wr_en;
    assign head_dst_o   = mem_q[head_q].dst;
    assign head_data_o  = mem_q[head_q].data;

endmodule

// File: rtl/wb_lane_buffer.sv
// Multi-lane write-back stage: stall generation, retire handshake and flush masking around the result FIFO.
module wb_lane_buffer
    import wb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             internal_reset,
    wb_lane_buffer_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0]  count;
    logic              head_wr_en;
    logic [ADDR_W-1:0] head_dst;
    logic [DATA_W-1:0] head_data;
    logic              fifo_hit;
    logic [DATA_W-1:0] fifo_byp_data;
    logic              stall;
    logic              ex_fire;
    logic              out_valid;
    logic              pop;
    logic              byp_hit;

    wb_result_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .LANES  (LANES),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (internal_reset),
        .push_en_i    (ex_fire),
        .push_valid_i (bus.ex_valid),
        .push_wr_en_i (bus.ex_wr_en),
        .push_dst_i   (bus.ex_dst),
        .push_data_i  (bus.ex_data),
        .pop_i        (pop),
        .count_o      (count),
        .head_wr_en_o (head_wr_en),
        .head_dst_o   (head_dst),
        .head_data_o  (head_data),
        .byp_addr_i   (bus.byp_addr),
        .byp_hit_o    (fifo_hit),
        .byp_data_o   (fifo_byp_data)
    );

    // Stall looks only at registered occupancy; a pop in the same cycle earns no credit.
    assign stall     = (DEPTH - int'(count)) < LANES;
    assign ex_fire   = (|bus.ex_valid) & ~stall & ~internal_reset;
    assign out_valid = (count != '0) & ~internal_reset;
    assign pop       = out_valid & bus.out_ready;
    assign byp_hit   = fifo_hit & ~internal_reset;

    assign bus.wb_stall  = stall;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? head_data : '0;
    assign bus.out_dst   = out_valid ? head_dst : '0;
    assign bus.rf_we     = pop & head_wr_en;
    assign bus.rf_addr   = out_valid ? head_dst : '0;
    assign bus.rf_data   = out_valid ? head_data : '0;
    assign bus.byp_hit   = byp_hit;
    assign bus.byp_data  = byp_hit ? fifo_byp_data : '0;

endmodule

// File: tb/tb_wb_lane_buffer.sv
// Directed bench: a 2-lane/4-deep buffer for the main scenarios and a 1-lane/3-deep one for wrap behaviour.
module tb_wb_lane_buffer;

    logic clk = 1'b0;
    logic rst_n;
    logic irst0;
    logic irst1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    wb_lane_buffer_if #(.DATA_W(16), .ADDR_W(3), .LANES(2)) bus0 ();
    wb_lane_buffer_if #(.DATA_W(16), .ADDR_W(3), .LANES(1)) bus1 ();

    wb_lane_buffer #(.DATA_W(16), .ADDR_W(3), .LANES(2), .DEPTH(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .internal_reset(irst0), .bus(bus0.slave)
    );

    wb_lane_buffer #(.DATA_W(16), .ADDR_W(3), .LANES(1), .DEPTH(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .internal_reset(irst1), .bus(bus1.slave)
    );

    task automatic drive_idle();
        bus0.ex_valid = 2'b00;
        bus0.ex_wr_en = 2'b00;
        bus0.ex_dst   = 6'd0;
        bus0.ex_data  = 32'd0;
        bus1.ex_valid = 1'b0;
        bus1.ex_wr_en = 1'b0;
        bus1.ex_dst   = 3'd0;
        bus1.ex_data  = 16'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        irst0 = 1'b0;
        irst1 = 1'b0;
        drive_idle();
        bus0.out_ready = 1'b0;
        bus0.byp_addr  = 3'd0;
        bus1.out_ready = 1'b0;
        bus1.byp_addr  = 3'd0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (bus0.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", bus0.out_valid); end
        n_cmp++; if (bus0.rf_we !== 1'b0) begin n_err++; $display("FAIL rst_rf_we: got %b want 0", bus0.rf_we); end
        n_cmp++; if (bus0.wb_stall !== 1'b0) begin n_err++; $display("FAIL rst_wb_stall: got %b want 0", bus0.wb_stall); end
        n_cmp++; if (bus0.byp_hit !== 1'b0) begin n_err++; $display("FAIL rst_byp_hit: got %b want 0", bus0.byp_hit); end
        n_cmp++; if (bus0.out_data !== 16'h0000) begin n_err++; $display("FAIL rst_out_data: got %h want 0000", bus0.out_data); end
        n_cmp++; if (bus0.byp_data !== 16'h0000) begin n_err++; $display("FAIL rst_byp_data: got %h want 0000", bus0.byp_data); end
        n_cmp++; if (bus1.out_valid !== 1'b0) begin n_err++; $display("FAIL rst1_out_valid: got %b want 0", bus1.out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        bus0.ex_valid  = 2'b01;
        bus0.ex_wr_en  = 2'b01;
        bus0.ex_dst    = {3'd0, 3'd3};
        bus0.ex_data   = {16'h0000, 16'h1234};
        bus0.out_ready = 1'b1;
        #1;
        n_cmp++; if (bus0.out_valid !== 1'b0) begin n_err++; $display("FAIL single_pre_valid: got %b want 0", bus0.out_valid); end
        @(negedge clk);
        drive_idle();
        #1;
        n_cmp++; if (bus0.out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", bus0.out_valid); end
        n_cmp++; if (bus0.rf_we !== 1'b1) begin n_err++; $display("FAIL single_rf_we: got %b want 1", bus0.rf_we); end
        n_cmp++; if (bus0.rf_addr !== 3'd3) begin n_err++; $display("FAIL single_rf_addr: got %0d want 3", bus0.rf_addr); end
        n_cmp++; if (bus0.rf_data !== 16'h1234) begin n_err++; $display("FAIL single_rf_data: got %h want 1234", bus0.rf_data); end
        n_cmp++; if (bus0.out_dst !== 3'd3) begin n_err++; $display("FAIL single_out_dst: got %0d want 3", bus0.out_dst); end
        @(negedge clk);
        #1;
        n_cmp++; if (bus0.out_valid !== 1'b0) begin n_err++; $display("FAIL single_drained: got %b want 0", bus0.out_valid); end
        n_cmp++; if (bus0.rf_we !== 1'b0) begin n_err++; $display("FAIL single_rf_we_off: got %b want 0", bus0.rf_we); end
        bus0.out_ready = 1'b0;
    endtask

    task automatic test_fill();
        logic [3:0]  exp_stall;
        logic [15:0] exp_data;
        exp_stall = 4'b1100;
        bus0.out_ready = 1'b0;
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            bus0.ex_valid = 2'b11;
            bus0.ex_wr_en = 2'b11;
            bus0.ex_dst   = {3'(2*g+1), 3'(2*g)};
            bus0.ex_data  = {16'(16'h0011 + 16'h0100*g), 16'(16'h0010 + 16'h0100*g)};
            #1;
            n_cmp++; if (bus0.wb_stall !== exp_stall[g]) begin n_err++; $display("FAIL fill_stall g%0d: got %b want %b", g, bus0.wb_stall, exp_stall[g]); end
        end
        @(negedge clk);
        drive_idle();
        #1;
        n_cmp++; if (bus0.out_data !== 16'h0010) begin n_err++; $display("FAIL fill_hold: got %h want 0010", bus0.out_data); end
        bus0.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_data = 16'(16'h0010 + 16'h0100*(k/2) + (k%2));
            #1;
            n_cmp++; if (bus0.out_valid !== 1'b1) begin n_err++; $display("FAIL fill_valid k%0d: got %b want 1", k, bus0.out_valid); end
            n_cmp++; if (bus0.out_dst !== 3'(k)) begin n_err++; $display("FAIL fill_dst k%0d: got %0d want %0d", k, bus0.out_dst, k); end
            n_cmp++; if (bus0.out_data !== exp_data) begin n_err++; $display("FAIL fill_data k%0d: got %h want %h", k, bus0.out_data, exp_data); end
            @(negedge clk);
        end
        #1;
        n_cmp++; if (bus0.out_valid !== 1'b0) begin n_err++; $display("FAIL fill_empty: got %b want 0", bus0.out_valid); end
        n_cmp++; if (bus0.wb_stall !== 1'b0) begin n_err++; $display("FAIL fill_unstall: got %b want 0", bus0.wb_stall); end
        bus0.out_ready = 1'b0;
    endtask

    task automatic test_nowrite();
        @(negedge clk);
        bus0.ex_valid = 2'b10;
        bus0.ex_wr_en = 2'b00;
        bus0.ex_dst   = {3'd5, 3'd1};
        bus0.ex_data  = {16'h5555, 16'h1111};
        @(negedge clk);
        drive_idle();
        bus0.byp_addr  = 3'd5;
        bus0.out_ready = 1'b1;
        #1;
        n_cmp++; if (bus0.out_valid !== 1'b1) begin n_err++; $display("FAIL nowr_valid: got %b want 1", bus0.out_valid); end
        n_cmp++; if (bus0.out_dst !== 3'd5) begin n_err++; $display("FAIL nowr_dst: got %0d want 5", bus0.out_dst); end
        n_cmp++; if (bus0.out_data !== 16'h5555) begin n_err++; $display("FAIL nowr_data: got %h want 5555", bus0.out_data); end
        n_cmp++; if (bus0.rf_we !== 1'b0) begin n_err++; $display("FAIL nowr_rf_we: got %b want 0", bus0.rf_we); end
        n_cmp++; if (bus0.byp_hit !== 1'b0) begin n_err++; $display("FAIL nowr_byp_hit: got %b want 0", bus0.byp_hit); end
        @(negedge clk);
        #1;
        n_cmp++; if (bus0.out_valid !== 1'b0) begin n_err++; $display("FAIL nowr_single: got %b want 0", bus0.out_valid); end
        bus0.out_ready = 1'b0;
    endtask

    task automatic test_bypass();
        @(negedge clk);
        bus0.ex_valid = 2'b11;
        bus0.ex_wr_en = 2'b11;
        bus0.ex_dst   = {3'd2, 3'd2};
        bus0.ex_data  = {16'hBBBB, 16'hAAAA};
        bus0.byp_addr = 3'd2;
        #1;
        n_cmp++; if (bus0.byp_hit !== 1'b0) begin n_err++; $display("FAIL byp_incoming: got %b want 0", bus0.byp_hit); end
        @(negedge clk);
        drive_idle();
        #1;
        n_cmp++; if (bus0.byp_hit !== 1'b1) begin n_err++; $display("FAIL byp_hit: got %b want 1", bus0.byp_hit); end
        n_cmp++; if (bus0.byp_data !== 16'hBBBB) begin n_err++; $display("FAIL byp_young: got %h want bbbb", bus0.byp_data); end
        n_cmp++; if (bus0.out_data !== 16'hAAAA) begin n_err++; $display("FAIL byp_head: got %h want aaaa", bus0.out_data); end
        bus0.out_ready = 1'b1;
        @(negedge clk);
        bus0.out_ready = 1'b0;
        #1;
        n_cmp++; if (bus0.byp_hit !== 1'b1) begin n_err++; $display("FAIL byp_hit_after_pop: got %b want 1", bus0.byp_hit); end
        n_cmp++; if (bus0.byp_data !== 16'hBBBB) begin n_err++; $display("FAIL byp_data_after_pop: got %h want bbbb", bus0.byp_data); end
        n_cmp++; if (bus0.out_data !== 16'hBBBB) begin n_err++; $display("FAIL byp_head2: got %h want bbbb", bus0.out_data); end
        bus0.byp_addr = 3'd3;
        #1;
        n_cmp++; if (bus0.byp_hit !== 1'b0) begin n_err++; $display("FAIL byp_miss_hit: got %b want 0", bus0.byp_hit); end
        n_cmp++; if (bus0.byp_data !== 16'h0000) begin n_err++; $display("FAIL byp_miss_data: got %h want 0000", bus0.byp_data); end
        bus0.out_ready = 1'b1;
        @(negedge clk);
        bus0.out_ready = 1'b0;
        #1;
        n_cmp++; if (bus0.out_valid !== 1'b0) begin n_err++; $display("FAIL byp_drained: got %b want 0", bus0.out_valid); end
    endtask

    task automatic test_flush();
        for (int g = 0; g < 2; g++) begin
            @(negedge clk);
            bus0.ex_valid = 2'b11;
            bus0.ex_wr_en = 2'b11;
            bus0.ex_dst   = {3'd7, 3'd6};
            bus0.ex_data  = {16'h7000, 16'h6000};
        end
        @(negedge clk);
        irst0          = 1'b1;
        bus0.out_ready = 1'b1;
        bus0.byp_addr  = 3'd7;
        #1;
        n_cmp++; if (bus0.wb_stall !== 1'b1) begin n_err++; $display("FAIL flush_full_stall: got %b want 1", bus0.wb_stall); end
        n_cmp++; if (bus0.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid: got %b want 0", bus0.out_valid); end
        n_cmp++; if (bus0.rf_we !== 1'b0) begin n_err++; $display("FAIL flush_rf_we: got %b want 0", bus0.rf_we); end
        n_cmp++; if (bus0.byp_hit !== 1'b0) begin n_err++; $display("FAIL flush_byp_hit: got %b want 0", bus0.byp_hit); end
        n_cmp++; if (bus0.out_data !== 16'h0000) begin n_err++; $display("FAIL flush_out_data: got %h want 0000", bus0.out_data); end
        @(negedge clk);
        irst0          = 1'b0;
        bus0.out_ready = 1'b0;
        drive_idle();
        #1;
        n_cmp++; if (bus0.wb_stall !== 1'b0) begin n_err++; $display("FAIL flush_after_stall: got %b want 0", bus0.wb_stall); end
        n_cmp++; if (bus0.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_after_valid: got %b want 0", bus0.out_valid); end
        n_cmp++; if (bus0.byp_hit !== 1'b0) begin n_err++; $display("FAIL flush_after_byp: got %b want 0", bus0.byp_hit); end
        @(negedge clk);
        irst0         = 1'b1;
        bus0.ex_valid = 2'b01;
        bus0.ex_wr_en = 2'b01;
        bus0.ex_dst   = {3'd0, 3'd1};
        bus0.ex_data  = {16'h0000, 16'h1111};
        @(negedge clk);
        irst0 = 1'b0;
        drive_idle();
        #1;
        n_cmp++; if (bus0.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_push: got %b want 0", bus0.out_valid); end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_data;
        bus1.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus1.ex_valid = 1'b1;
            bus1.ex_wr_en = 1'b1;
            bus1.ex_dst   = 3'(k);
            bus1.ex_data  = 16'(16'hA000 + k);
            if (k >= 2) begin
                bus1.out_ready = 1'b1;
                exp_data = 16'(16'hA000 + k - 2);
                #1;
                n_cmp++; if (bus1.wb_stall !== 1'b0) begin n_err++; $display("FAIL wrap_stall k%0d: got %b want 0", k, bus1.wb_stall); end
                n_cmp++; if (bus1.out_valid !== 1'b1) begin n_err++; $display("FAIL wrap_valid k%0d: got %b want 1", k, bus1.out_valid); end
                n_cmp++; if (bus1.out_data !== exp_data) begin n_err++; $display("FAIL wrap_data k%0d: got %h want %h", k, bus1.out_data, exp_data); end
            end
        end
        for (int k = 5; k < 7; k++) begin
            @(negedge clk);
            drive_idle();
            exp_data = 16'(16'hA000 + k - 2);
            #1;
            n_cmp++; if (bus1.out_data !== exp_data) begin n_err++; $display("FAIL wrap_drain k%0d: got %h want %h", k, bus1.out_data, exp_data); end
        end
        @(negedge clk);
        bus1.out_ready = 1'b0;
        #1;
        n_cmp++; if (bus1.out_valid !== 1'b0) begin n_err++; $display("FAIL wrap_empty: got %b want 0", bus1.out_valid); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus1.ex_valid = 1'b1;
            bus1.ex_wr_en = 1'b1;
            bus1.ex_dst   = 3'(k + 4);
            bus1.ex_data  = 16'(16'hC000 + k);
        end
        @(negedge clk);
        drive_idle();
        #1;
        n_cmp++; if (bus1.wb_stall !== 1'b1) begin n_err++; $display("FAIL wrap_full_stall: got %b want 1", bus1.wb_stall); end
        n_cmp++; if (bus1.out_data !== 16'hC000) begin n_err++; $display("FAIL wrap_full_head: got %h want c000", bus1.out_data); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_nowrite();
        test_bypass();
        test_flush();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
